// File: rtl/hmc7044_spi_master.sv
`default_nettype none
// ============================================================================
// Module   : hmc7044_spi_master
// Purpose  : Local-bus to 3-wire SPI bridge for the HMC7044 clock chip.
//            Each request sends one 24-bit frame {RNW, 2'b00, ADR[12:0], DATA},
//            MSB first. On reads the SDIO pin is released for the last 8 bits
//            and the returned byte is captured into LB_RDAT.
// Ports    : CLK, RST           - clock, synchronous active-high reset
//            LB_REQ/RNW/ADR/WDAT - request side (REQ held until LB_ACK)
//            LB_RDAT, LB_ACK    - read data, one-cycle completion pulse
//            SPI_CSN/SCLK/SDO/SDO_OE/SDI - 3-wire SPI pins (SDIO split)
//            BUSY               - high while a transaction is in flight
// Revision : 1.0 - initial release
// ============================================================================
module hmc7044_spi_master #(
  parameter int CLK_DIV  = 4,  // SCLK half-period in CLK cycles (2..255)
  parameter int CS_SETUP = 2,  // CSN fall to first SCLK low phase (1..15)
  parameter int CS_HOLD  = 2   // last SCLK fall to CSN rise (1..15)
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        LB_REQ,
  input  logic        LB_RNW,
  input  logic [14:0] LB_ADR,
  input  logic [7:0]  LB_WDAT,
  output logic [7:0]  LB_RDAT,
  output logic        LB_ACK,
  output logic        SPI_CSN,
  output logic        SPI_SCLK,
  output logic        SPI_SDO,
  output logic        SPI_SDO_OE,
  input  logic        SPI_SDI,
  output logic        BUSY
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4,
    GAP   = 3'd5
  } state_t;

  localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
  localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(CS_HOLD - 1);

  state_t      state_q;
  logic [7:0]  cnt_q;     // shared setup / divider / hold counter
  logic [4:0]  bit_q;     // current frame bit, 23 down to 0
  logic [23:0] frame_q;
  logic        rnw_q;
  logic [7:0]  shreg_q;   // read data being assembled, MSB first
  logic        csn_q, sclk_q, sdo_q, oe_q, ack_q, busy_q;
  logic [7:0]  rdat_q;

  logic [23:0] frame_d;
  logic [7:0]  shreg_d;
  logic        unused_adr_hi;

  assign frame_d       = {LB_RNW, 2'b00, LB_ADR[12:0], LB_WDAT};
  assign shreg_d       = {shreg_q[6:0], SPI_SDI};
  assign unused_adr_hi = ^LB_ADR[14:13];

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      bit_q   <= 5'd0;
      frame_q <= 24'd0;
      rnw_q   <= 1'b0;
      shreg_q <= 8'd0;
      csn_q   <= 1'b1;
      sclk_q  <= 1'b0;
      sdo_q   <= 1'b0;
      oe_q    <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      rdat_q  <= 8'd0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (LB_REQ) begin
            // Latch everything now so later bus changes cannot leak in.
            frame_q <= frame_d;
            rnw_q   <= LB_RNW;
            csn_q   <= 1'b0;
            sdo_q   <= frame_d[23];
            oe_q    <= 1'b1;
            busy_q  <= 1'b1;
            cnt_q   <= 8'd0;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          if (cnt_q == SETUP_LAST) begin
            cnt_q   <= 8'd0;
            bit_q   <= 5'd23;
            state_q <= SHIFT;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        SHIFT: begin
          if (cnt_q != DIV_LAST) begin
            cnt_q <= cnt_q + 8'd1;
          end else begin
            cnt_q <= 8'd0;
            if (!sclk_q) begin
              sclk_q <= 1'b1;
            end else begin
              // Last cycle of the high phase: sample, then fall and advance.
              sclk_q <= 1'b0;
              if (rnw_q && (bit_q < 5'd8)) shreg_q <= shreg_d;
              if (bit_q == 5'd0) begin
                state_q <= HOLD;
              end else begin
                bit_q <= bit_q - 5'd1;
                sdo_q <= frame_q[bit_q - 5'd1];
                // Turn the SDIO line around for the chip's data byte.
                if (rnw_q && (bit_q == 5'd8)) oe_q <= 1'b0;
              end
            end
          end
        end
        HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            cnt_q   <= 8'd0;
            csn_q   <= 1'b1;
            ack_q   <= 1'b1;
            oe_q    <= 1'b0;
            sdo_q   <= 1'b0;
            if (rnw_q) rdat_q <= shreg_q;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        DONE: state_q <= GAP;
        GAP: begin
          // Requests are ignored here so a requester dropping REQ one
          // cycle after ACK never triggers a duplicate frame.
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign LB_RDAT    = rdat_q;
  assign LB_ACK     = ack_q;
  assign SPI_CSN    = csn_q;
  assign SPI_SCLK   = sclk_q;
  assign SPI_SDO    = sdo_q;
  assign SPI_SDO_OE = oe_q;
  assign BUSY       = busy_q;

endmodule
`default_nettype wire

// File: doc/hmc7044_spi_master.md
HMC7044_SPI_MASTER -- requirements
Module: hmc7044_spi_master

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 4, giving the SCLK half-period in CLK cycles (legal range 2..255).
REQ-002 The block SHALL have parameter CS_SETUP, default 2, giving CLK cycles from CSN fall to the first SCLK low phase (legal range 1..15).
REQ-003 The block SHALL have parameter CS_HOLD, default 2, giving CLK cycles from the last SCLK fall to CSN rise (legal range 1..15).
REQ-004 Reset SHALL be RST, synchronous, active-high, and the clock SHALL be CLK.
REQ-005 Ports (name, direction, width, meaning):
- CLK, in, 1: clock.
- RST, in, 1: synchronous active-high reset.
- LB_REQ, in, 1: request; requester holds it high until LB_ACK.
- LB_RNW, in, 1: 1 = read, 0 = write.
- LB_ADR, in, 15: register address; only bits [12:0] are used.
- LB_WDAT, in, 8: write data.
- LB_RDAT, out, 8: read data.
- LB_ACK, out, 1: one-cycle completion pulse.
- SPI_CSN, out, 1: chip select, active-low.
- SPI_SCLK, out, 1: serial clock, idles low.
- SPI_SDO, out, 1: SDIO output value.
- SPI_SDO_OE, out, 1: SDIO output enable (1 = drive).
- SPI_SDI, in, 1: SDIO input value.
- BUSY, out, 1: high while a transaction is in flight.

Function
REQ-006 The FSM SHALL have states IDLE, SETUP, SHIFT, HOLD, DONE and GAP.
- IDLE -> SETUP on LB_REQ=1.
- SETUP -> SHIFT after CS_SETUP cycles.
- SHIFT -> HOLD after 24 bits.
- HOLD -> DONE after CS_HOLD cycles.
- DONE -> GAP after 1 cycle.
- GAP -> IDLE after 1 cycle.
REQ-007 In IDLE with LB_REQ=1 at cycle N, the block SHALL latch the 24-bit frame {LB_RNW, 2'b00, LB_ADR[12:0], LB_WDAT} and LB_RNW; later input changes SHALL have no effect on the transaction.
REQ-008 From cycle N+1, SPI_CSN SHALL be 0 and SPI_SDO SHALL present frame bit 23, with the frame sent MSB first.
REQ-009 Each SHIFT bit SHALL take CLK_DIV cycles with SCLK=0 followed by CLK_DIV cycles with SCLK=1; SDO SHALL change only on the SCLK high-to-low transition (or at CSN fall for bit 23).
REQ-010 For a write, SPI_SDO_OE SHALL be 1 for all 24 bits.
REQ-011 For a read, SPI_SDO_OE SHALL be 1 for bits 23..8 and 0 from the SCLK fall ending bit 8 until the next transaction.
REQ-012 For a read, SPI_SDI SHALL be sampled on the last CLK cycle of each SCLK-high phase for bits 7..0, and the 8 samples SHALL be assembled MSB first.
REQ-013 After bit 0, SCLK SHALL return low, and CSN SHALL stay 0 for CS_HOLD cycles (HOLD).
REQ-014 In DONE, the block SHALL drive CSN=1 and LB_ACK=1 for exactly one cycle.
REQ-015 For a read, LB_RDAT SHALL update in the DONE cycle and hold that value until the next read completes; writes SHALL NOT change LB_RDAT.
REQ-016 LB_ACK SHALL occur at cycle N+1+CS_SETUP+48*CLK_DIV+CS_HOLD, which is N+197 with default parameters.
REQ-017 In GAP, LB_REQ SHALL be ignored, so a requester that clears LB_REQ one cycle after LB_ACK never starts a duplicate transaction.
REQ-018 If LB_REQ is still high in IDLE after GAP, a new transaction SHALL start; back-to-back CSN-high time SHALL be at least 2 cycles.
REQ-019 BUSY SHALL be 1 in every state except IDLE.
REQ-020 In IDLE, the outputs SHALL be CSN=1, SCLK=0, SDO_OE=0 and SDO=0.
REQ-021 The SCLK divider count SHALL wrap from CLK_DIV-1 to 0 and the bit counter SHALL count 23 down to 0, with no overflow beyond 24 bits.

Reset
REQ-022 While RST=1, the block SHALL force state IDLE, CSN=1, SCLK=0, SDO=0, SDO_OE=0, LB_ACK=0, BUSY=0 and LB_RDAT=8'h00, with all counters cleared.
REQ-023 RST asserted mid-transaction SHALL abort the frame immediately (CSN=1 in the cycle after RST is sampled), with no LB_ACK ever generated for the aborted request.
REQ-024 After RST deasserts, a held LB_REQ SHALL start a fresh transaction from IDLE.

Verification
REQ-025 Write, default parameters: LB_ADR=15'h0001, LB_WDAT=8'h5A, RNW=0.
- SDO across the 24 SCLK rises SHALL read 24'h00015A.
- SDO_OE SHALL stay 1 throughout.
- LB_ACK SHALL pulse at N+197.
REQ-026 Read: LB_ADR=15'h0078, RNW=1, SDI model drives 8'hA5.
- The first 16 bits SHALL read 16'h8078.
- SDO_OE SHALL be 0 for the last 8 bits.
- LB_RDAT SHALL equal 8'hA5 at LB_ACK and remain so after a following write.
REQ-027 Upper address bits: LB_ADR=15'h7FFF, write, data 8'h00 -> the frame SHALL equal 24'h1FFF00.
REQ-028 Handshake: the requester drops LB_REQ the cycle after LB_ACK -> exactly one frame SHALL occur; with LB_REQ held high -> a second frame SHALL start with at least 2 cycles of CSN high.
REQ-029 Reset mid-frame: RST=1 at bit 10 -> CSN=1, SCLK=0, SDO_OE=0 next cycle, no LB_ACK, LB_RDAT=8'h00, and a new request completes normally.
REQ-030 CLK_DIV=2, CS_SETUP=1, CS_HOLD=1 -> LB_ACK SHALL pulse at N+99 and the SCLK period SHALL be 4 CLK cycles.
